wrr_port_scheduler: RTL and testbench

Weighted round-robin scheduler that moves words from the four input-port FIFOs to the four output-port FIFOs. Each cycle it picks at most one non-empty input FIFO and pops it. It then routes the returned word to the output FIFO selected by the word's destination field. Global output backpressure halts new pops. It sits between the input FIFO bank and the output FIFO bank as the transaction-layer traffic sequencer, and holds its own init/idle/active FSM.

---
 rtl/wrr_port_scheduler_pkg.sv | 21 ++
 rtl/wrr_port_scheduler_if.sv | 25 ++
 rtl/wrr_port_scheduler_rr_pick.sv | 27 ++
 rtl/wrr_port_scheduler.sv | 114 +++++++++++
 tb/tb_wrr_port_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_port_scheduler_pkg.sv
// Shared types and constants for the transaction-layer scheduler family.
// Imported by the scheduler, its interface and its arbiter helpers.
package tl_sched_pkg;

  localparam int N_Q        = 4;
  localparam int Q_WEIGHT_W = 3;
  localparam int Q_DEST_LSB = 8;
  localparam int Q_DEST_W   = 2;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  function automatic logic [N_Q-1:0] onehot(input logic [1:0] idx);
    return N_Q'(1) << idx;
  endfunction

endpackage

// File: rtl/wrr_port_scheduler_if.sv
// FIFO-side bundle of the scheduler: input-bank pop/data and output-bank push/data.
// master = scheduler, slave = FIFO banks.
interface wrr_port_scheduler_if #(
  parameter int DATA_W = 12
);
  import tl_sched_pkg::*;

  logic [N_Q-1:0]    empty;
  logic [N_Q-1:0]    pop;
  logic [DATA_W-1:0] data_in;
  logic [N_Q-1:0]    almost_full;
  logic [N_Q-1:0]    push;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  empty, data_in, almost_full,
    output pop, push, data_out
  );

  modport slave (
    output empty, data_in, almost_full,
    input  pop, push, data_out
  );

endinterface

// File: rtl/wrr_port_scheduler_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping mod 4.
module rr_pick
  import tl_sched_pkg::*;
(
  input  logic [N_Q-1:0] req,
  input  logic [1:0]     ptr,
  output logic           gnt_valid,
  output logic [1:0]     gnt_idx
);

  logic [1:0] idx;

  // Scan from farthest to nearest so the closest request to ptr is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = N_Q - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/wrr_port_scheduler.sv
// Weighted round-robin mover from four input FIFOs to four output FIFOs,
// routing each word by its 2-bit destination field with a 2-cycle pop-to-push pipe.
module wrr_port_scheduler
  import tl_sched_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int WEIGHT_W = Q_WEIGHT_W,
  parameter int DEST_LSB = Q_DEST_LSB
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [N_Q*WEIGHT_W-1:0] weight_cfg,
  wrr_port_scheduler_if.master    bus,
  output logic [1:0]              grant_idx,
  output logic [4:0]              pkt_count,
  output logic                    idle
);

  state_e              state, state_nxt;
  logic [WEIGHT_W-1:0] weight [N_Q];
  logic [1:0]          ptr, ptr_nxt, nxt_idx;
  logic [WEIGHT_W-1:0] credit, credit_nxt, cnt;
  logic [N_Q-1:0]      elig;
  logic                gnt_valid, grant, v1;
  logic [1:0]          gnt_idx;
  logic [N_Q-1:0]      push_q;
  logic [DATA_W-1:0]   data_q;

  function automatic logic [WEIGHT_W-1:0] clamp_w(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  // Any output near full stalls every queue, leaving headroom for the two words in flight.
  assign elig = ~bus.empty & {N_Q{~|bus.almost_full}};

  rr_pick u_pick (
    .req       (elig),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    grant      = 1'b0;
    cnt        = '0;
    nxt_idx    = gnt_idx + 2'd1;
    case (state)
      ST_RESET: state_nxt = ST_INIT;
      ST_INIT: begin
        ptr_nxt    = '0;
        credit_nxt = clamp_w(weight_cfg[0 +: WEIGHT_W]);
        if (!init) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (init)           state_nxt = ST_INIT;
        else if (gnt_valid) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        grant = gnt_valid;
        if (init)            state_nxt = ST_INIT;
        else if (!gnt_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_RESET;
    endcase
    // A queue skipped over restarts with its full weight; the pointed queue spends its credit.
    if (grant) begin
      cnt = (gnt_idx == ptr) ? credit : weight[gnt_idx];
      if (cnt == WEIGHT_W'(1)) begin
        ptr_nxt    = nxt_idx;
        credit_nxt = weight[nxt_idx];
      end else begin
        ptr_nxt    = gnt_idx;
        credit_nxt = cnt - WEIGHT_W'(1);
      end
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RESET;
      ptr       <= '0;
      credit    <= '0;
      v1        <= 1'b0;
      push_q    <= '0;
      data_q    <= '0;
      pkt_count <= '0;
      // NOTE: the weight bank is only four small registers, so it is reset rather than left unknown.
      for (int i = 0; i < N_Q; i++) weight[i] <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      credit <= credit_nxt;
      if (state == ST_INIT) begin
        for (int i = 0; i < N_Q; i++) weight[i] <= clamp_w(weight_cfg[i*WEIGHT_W +: WEIGHT_W]);
      end
      v1     <= grant;
      push_q <= v1 ? onehot(bus.data_in[DEST_LSB +: Q_DEST_W]) : '0;
      data_q <= v1 ? bus.data_in : '0;
      if (v1) pkt_count <= pkt_count + 5'd1;
    end
  end

  assign bus.pop      = grant ? onehot(gnt_idx) : '0;
  assign grant_idx    = grant ? gnt_idx : '0;
  assign bus.push     = push_q;
  assign bus.data_out = data_q;
  assign idle         = (state == ST_IDLE) && !v1 && (push_q == '0);

endmodule

// File: tb/tb_wrr_port_scheduler.sv
// Bench for wrr_port_scheduler: pop-order vector table plus a push scoreboard
// that checks routing, data, latency and the running word count.
module tb_wrr_port_scheduler;
  import tl_sched_pkg::*;

  localparam int DATA_W = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init = 1'b1;
  logic [11:0] weight_cfg = 12'h249;
  logic [1:0]  grant_idx;
  logic [4:0]  pkt_count;
  logic        idle;

  wrr_port_scheduler_if #(.DATA_W(DATA_W)) bus ();

  wrr_port_scheduler #(.DATA_W(DATA_W), .WEIGHT_W(3), .DEST_LSB(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .weight_cfg (weight_cfg),
    .bus        (bus),
    .grant_idx  (grant_idx),
    .pkt_count  (pkt_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        init;
    logic [11:0] wcfg;
    logic [3:0]  empty;
    logic [3:0]  af;
    logic [3:0]  pop;
    logic [1:0]  gnt;
    logic        idle;
  } vec_t;

  typedef struct {
    logic [11:0] word;
    int          due;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        pend_valid = 1'b0;
  logic [11:0] pend_word = '0;
  logic        ovr_en = 1'b0;
  logic [4:0]  exp_pkt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input string n, input logic i, input logic [11:0] w, input logic [3:0] e,
                     input logic [3:0] a, input logic [3:0] p, input logic [1:0] g, input logic id);
    vec_t v;
    v.name = n; v.init = i; v.wcfg = w; v.empty = e; v.af = a; v.pop = p; v.gnt = g; v.idle = id;
    vecs.push_back(v);
  endtask

  // Returns the popped word one cycle later; junk otherwise so a mistimed sample shows up.
  task automatic driver_loop();
    forever begin
      @(posedge clk);
      cyc++;
      #1 bus.data_in = pend_valid ? pend_word : 12'hFFF;
    end
  endtask

  task automatic monitor_loop();
    sb_t         e;
    logic [11:0] w;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb.delete();
        pend_valid = 1'b0;
        exp_pkt    = '0;
      end else begin
        if (bus.push != '0) begin
          if (sb.size() == 0) begin
            check("push_unexpected", 32'(bus.push), 32'd0);
          end else begin
            e = sb.pop_front();
            check("push_dest", 32'(bus.push), 32'(onehot(e.word[9:8])));
            check("push_data", 32'(bus.data_out), 32'(e.word));
            check("push_latency", cyc, e.due);
            exp_pkt = exp_pkt + 5'd1;
            check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
          end
        end else begin
          check("data_out_zero", 32'(bus.data_out), 32'd0);
          if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("push_missing", 32'(bus.push), 32'(onehot(sb[0].word[9:8])));
            void'(sb.pop_front());
          end
        end
        pend_valid = (bus.pop != '0);
        if (pend_valid) begin
          check("pop_onehot", 32'(bus.pop), 32'(onehot(grant_idx)));
          w = (ovr_en && bus.pop == 4'b0010) ? 12'h3A5 : 12'($urandom);
          pend_word = w;
          sb.push_back('{word: w, due: cyc + 2});
        end
      end
    end
  endtask

  initial begin
    logic [4:0] pkt0;
    logic       found;

    bus.empty       = 4'hF;
    bus.almost_full = 4'h0;
    bus.data_in     = 12'hFFF;

    //   name         init wcfg    empty af    pop     gnt idle
    add("init_hold",   1, 12'h249, 4'hF, 4'h0, 4'h0, 0, 0);
    add("init_rel",    0, 12'h249, 4'h0, 4'h0, 4'h0, 0, 0);
    add("idle_elig",   0, 12'h249, 4'h0, 4'h0, 4'h0, 0, 1);
    add("rr_q0",       0, 12'h249, 4'h0, 4'h0, 4'h1, 0, 0);
    add("rr_q1",       0, 12'h249, 4'h0, 4'h0, 4'h2, 1, 0);
    add("rr_q2",       0, 12'h249, 4'h0, 4'h0, 4'h4, 2, 0);
    add("rr_q3",       0, 12'h249, 4'h0, 4'h0, 4'h8, 3, 0);
    add("rr_q0b",      0, 12'h249, 4'h0, 4'h0, 4'h1, 0, 0);
    add("rr_q1b",      0, 12'h249, 4'h0, 4'h0, 4'h2, 1, 0);
    add("af_block",    0, 12'h249, 4'h0, 4'h4, 4'h0, 0, 0);
    add("af_drain",    0, 12'h249, 4'h0, 4'h4, 4'h0, 0, 0);
    add("af_idle",     0, 12'h249, 4'h0, 4'h4, 4'h0, 0, 1);
    add("af_release",  0, 12'h249, 4'h0, 4'h0, 4'h0, 0, 1);
    add("resume_q2",   0, 12'h249, 4'h0, 4'h0, 4'h4, 2, 0);
    add("resume_q3",   0, 12'h249, 4'h0, 4'h0, 4'h8, 3, 0);
    add("init_act",    1, 12'h00B, 4'hC, 4'h0, 4'h1, 0, 0);
    add("init2_hold",  1, 12'h00B, 4'hC, 4'h0, 4'h0, 0, 0);
    add("init2_rel",   0, 12'h00B, 4'hC, 4'h0, 4'h0, 0, 0);
    add("idle2",       0, 12'h00B, 4'hC, 4'h0, 4'h0, 0, 1);
    add("w3_a0",       0, 12'h00B, 4'hC, 4'h0, 4'h1, 0, 0);
    add("w3_a1",       0, 12'h00B, 4'hC, 4'h0, 4'h1, 0, 0);
    add("w3_a2",       0, 12'h00B, 4'hC, 4'h0, 4'h1, 0, 0);
    add("w3_a3",       0, 12'h00B, 4'hC, 4'h0, 4'h2, 1, 0);
    add("w3_b0",       0, 12'h00B, 4'hC, 4'h0, 4'h1, 0, 0);
    add("w3_b1",       0, 12'h00B, 4'hC, 4'h0, 4'h1, 0, 0);
    add("w3_b2",       0, 12'h00B, 4'hC, 4'h0, 4'h1, 0, 0);
    add("w3_b3",       0, 12'h00B, 4'hC, 4'h0, 4'h2, 1, 0);
    add("init3_act",   1, 12'h008, 4'hC, 4'h0, 4'h1, 0, 0);
    add("init3_hold",  1, 12'h008, 4'hC, 4'h0, 4'h0, 0, 0);
    add("init3_rel",   0, 12'h008, 4'hC, 4'h0, 4'h0, 0, 0);
    add("idle3",       0, 12'h008, 4'hC, 4'h0, 4'h0, 0, 1);
    add("w0_a0",       0, 12'h008, 4'hC, 4'h0, 4'h1, 0, 0);
    add("w0_a1",       0, 12'h008, 4'hC, 4'h0, 4'h2, 1, 0);
    add("w0_b0",       0, 12'h008, 4'hC, 4'h0, 4'h1, 0, 0);
    add("w0_b1",       0, 12'h008, 4'hC, 4'h0, 4'h2, 1, 0);
    add("drain_act",   0, 12'h008, 4'hF, 4'h0, 4'h0, 0, 0);
    add("drain_push",  0, 12'h008, 4'hF, 4'h0, 4'h0, 0, 0);
    add("drain_idle",  0, 12'h008, 4'hF, 4'h0, 4'h0, 0, 1);

    fork
      monitor_loop();
      driver_loop();
    join_none

    repeat (2) @(negedge clk);
    check("rst_pop",      32'(bus.pop),      32'd0);
    check("rst_push",     32'(bus.push),     32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_grant",    32'(grant_idx),    32'd0);
    check("rst_pkt",      32'(pkt_count),    32'd0);
    check("rst_idle",     32'(idle),         32'd0);
    #2 reset = 1'b1;

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      init            = vecs[k].init;
      weight_cfg      = vecs[k].wcfg;
      bus.empty       = vecs[k].empty;
      bus.almost_full = vecs[k].af;
      @(negedge clk);
      check({vecs[k].name, "_pop"},  32'(bus.pop),   32'(vecs[k].pop));
      check({vecs[k].name, "_gnt"},  32'(grant_idx), 32'(vecs[k].gnt));
      check({vecs[k].name, "_idle"}, 32'(idle),      32'(vecs[k].idle));
    end

    // Known word through q1 lands on output 3 exactly two cycles after its pop.
    ovr_en = 1'b1;
    @(posedge clk);
    #1 bus.empty = 4'b1101;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (bus.pop == 4'b0010) found = 1'b1;
    end
    check("q1_pop_seen", 32'(found), 32'd1);
    @(posedge clk);
    #1 bus.empty = 4'hF;
    @(negedge clk);
    pkt0 = pkt_count;
    @(negedge clk);
    check("q1_push_3a5", 32'(bus.push),     32'h8);
    check("q1_data_3a5", 32'(bus.data_out), 32'h3A5);
    check("q1_pkt_inc",  32'(pkt_count),    32'(5'(pkt0 + 5'd1)));
    @(posedge clk);
    #1 ovr_en = 1'b0;

    // Long stream (wraps pkt_count), then reset with words in flight.
    bus.empty = 4'h0;
    repeat (40) @(negedge clk);
    check("stream_push", 32'(bus.push != '0), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_pop",      32'(bus.pop),      32'd0);
    check("mid_rst_push",     32'(bus.push),     32'd0);
    check("mid_rst_data_out", 32'(bus.data_out), 32'd0);
    check("mid_rst_grant",    32'(grant_idx),    32'd0);
    check("mid_rst_pkt",      32'(pkt_count),    32'd0);
    check("mid_rst_idle",     32'(idle),         32'd0);
    init      = 1'b1;
    bus.empty = 4'hF;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("post_rst_init_idle", 32'(idle), 32'd0);
    @(posedge clk);
    #1 init = 1'b0;
    @(negedge clk);
    check("post_rst_rel_idle", 32'(idle), 32'd0);
    @(negedge clk);
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_pop",  32'(bus.pop), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
